// File: rtl/fifo_rd_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_rd_arbiter_pkg
// Description : State encoding and output-buffer entry layout for the
//               read-side FIFO arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_rd_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_GAP  = 2'd2
    } arb_state_t;

    // Buffer entry is {src, last, data}; data occupies the low bits.
    function automatic int entry_last_bit(input int dsize);
        return dsize;
    endfunction

    function automatic int entry_src_lsb(input int dsize);
        return dsize + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/arb_out_buf.sv
`default_nettype none
// ============================================================================
// Module      : arb_out_buf
// Description : Two-entry output FIFO with occupancy and a strobe that marks
//               the newest stored (or incoming) entry as end-of-burst.
// Revision    : 1.0 - initial release
// ============================================================================
module arb_out_buf #(
    parameter int WIDTH    = 11,
    parameter int LAST_BIT = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    input  logic             i_set_last,
    output logic [WIDTH-1:0] o_head,
    output logic [1:0]       o_occ
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_occ;
    logic [WIDTH-1:0] w_push_word;
    logic             w_pop;

    assign w_pop  = i_pop && (r_occ != 2'd0);
    assign o_head = r_mem[r_rd_ptr];
    assign o_occ  = r_occ;

    // A word arriving together with the strobe is itself the tail.
    always_comb begin
        w_push_word           = i_push_data;
        w_push_word[LAST_BIT] = i_push_data[LAST_BIT] | i_set_last;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_occ    <= 2'd0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= w_push_word;
                r_wr_ptr        <= ~r_wr_ptr;
            end else if (i_set_last && (r_occ != 2'd0)) begin
                r_mem[~r_wr_ptr][LAST_BIT] <= 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_occ <= r_occ + {1'b0, i_push} - {1'b0, w_pop};
        end
    end

endmodule
`default_nettype wire

// File: rtl/fifo_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_rd_arbiter
// Description : Round-robin burst reader for NREQ FIFO read ports, merging
//               the words into one valid/ready stream tagged with src/last.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_rd_arbiter
    import fifo_rd_arbiter_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int SRCW  = 2,
    parameter int DSIZE = 8,
    parameter int ASIZE = 4,
    parameter int BURST = 4
) (
    input  logic                      rd_clk,
    input  logic                      rd_rst_n,
    input  logic [NREQ-1:0]           fifo_empty,
    input  logic [NREQ*(ASIZE+1)-1:0] fifo_rd_count,
    input  logic [NREQ*DSIZE-1:0]     fifo_dout,
    output logic [NREQ-1:0]           fifo_rd_en,
    output logic [DSIZE-1:0]          m_data,
    output logic [SRCW-1:0]           m_src,
    output logic                      m_last,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [NREQ-1:0]           grant,
    output logic                      busy
);

    localparam int              c_cw       = ASIZE + 1;
    localparam int              c_ew       = SRCW + 1 + DSIZE;
    localparam int              c_last_bit = entry_last_bit(DSIZE);
    localparam int              c_src_lsb  = entry_src_lsb(DSIZE);
    localparam logic [ASIZE:0]  c_burst    = c_cw'(BURST);
    localparam logic [ASIZE:0]  c_one      = c_cw'(1);
    localparam logic [NREQ-1:0] c_req_one  = NREQ'(1);
    localparam logic [SRCW-1:0] c_last_idx = SRCW'(NREQ - 1);

    arb_state_t      r_state;
    logic [SRCW-1:0] r_ptr;
    logic [SRCW-1:0] r_gidx;
    logic [NREQ-1:0] r_grant;
    logic [ASIZE:0]  r_remaining;
    logic            r_inflight;
    logic            r_rd_last;

    int              w_idx;
    logic            w_found;
    logic [SRCW-1:0] w_pick;
    logic [ASIZE:0]  w_pick_cnt;
    logic [ASIZE:0]  w_len;
    logic [SRCW-1:0] w_next_ptr;
    logic            w_rd;
    logic            w_early;
    logic            w_pop;
    logic            w_credit;
    logic [1:0]      w_occ;
    logic [c_ew-1:0] w_head;
    logic [c_ew-1:0] w_push_data;
    logic [DSIZE-1:0] w_dout;

    // Scan downwards so the eligible requester closest to the pointer wins.
    always_comb begin
        w_idx      = 0;
        w_found    = 1'b0;
        w_pick     = '0;
        w_pick_cnt = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_idx = (int'(r_ptr) + k) % NREQ;
            if (!fifo_empty[w_idx]) begin
                w_found    = 1'b1;
                w_pick     = SRCW'(w_idx);
                w_pick_cnt = fifo_rd_count[w_idx*c_cw +: c_cw];
            end
        end
    end

    // The count lags the empty flag, so a zero count still earns one read.
    assign w_len = (w_pick_cnt == '0)     ? c_one   :
                   (w_pick_cnt > c_burst) ? c_burst : w_pick_cnt;

    assign w_next_ptr  = (r_gidx == c_last_idx) ? '0 : r_gidx + SRCW'(1);
    assign w_dout      = fifo_dout[int'(r_gidx)*DSIZE +: DSIZE];
    assign w_pop       = (w_occ != 2'd0) && m_ready;
    assign w_credit    = ({1'b0, w_occ} + {2'b0, r_inflight}) < (3'd2 + {2'b0, w_pop});
    assign w_rd        = (r_state == ST_READ) && !fifo_empty[r_gidx] && w_credit &&
                         (r_remaining != '0);
    assign w_early     = (r_state == ST_READ) && fifo_empty[r_gidx];
    assign w_push_data = {r_gidx, r_rd_last, w_dout};

    assign fifo_rd_en = w_rd ? (c_req_one << r_gidx) : '0;
    assign grant      = r_grant;
    assign m_valid    = (w_occ != 2'd0);
    assign m_data     = w_head[DSIZE-1:0];
    assign m_last     = w_head[c_last_bit];
    assign m_src      = w_head[c_src_lsb +: SRCW];
    assign busy       = (r_state != ST_IDLE) || (w_occ != 2'd0);

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_gidx      <= '0;
            r_grant     <= '0;
            r_remaining <= '0;
            r_inflight  <= 1'b0;
            r_rd_last   <= 1'b0;
        end else begin
            r_inflight <= w_rd;
            r_rd_last  <= w_rd && (r_remaining == c_one);
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_gidx      <= w_pick;
                        r_grant     <= c_req_one << w_pick;
                        r_remaining <= w_len;
                        r_state     <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (w_rd) begin
                        r_remaining <= r_remaining - c_one;
                        if (r_remaining == c_one) begin
                            r_ptr   <= w_next_ptr;
                            r_state <= ST_GAP;
                        end
                    end else if (w_early) begin
                        r_ptr   <= w_next_ptr;
                        r_state <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    r_grant <= '0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    arb_out_buf #(
        .WIDTH    (c_ew),
        .LAST_BIT (c_last_bit)
    ) u_out_buf (
        .clk         (rd_clk),
        .rst_n       (rd_rst_n),
        .i_push      (r_inflight),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .i_set_last  (w_early),
        .o_head      (w_head),
        .o_occ       (w_occ)
    );

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_rd_arbiter
// Description : Directed bench with behavioural NORMAL-mode FIFO models.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_rd_arbiter;

    localparam int NREQ  = 4;
    localparam int SRCW  = 2;
    localparam int DSIZE = 8;
    localparam int ASIZE = 4;
    localparam int BURST = 4;

    logic                      rd_clk = 1'b0;
    logic                      rd_rst_n = 1'b1;
    logic [NREQ-1:0]           fifo_empty;
    logic [NREQ*(ASIZE+1)-1:0] fifo_rd_count;
    logic [NREQ*DSIZE-1:0]     fifo_dout;
    logic [NREQ-1:0]           fifo_rd_en;
    logic [DSIZE-1:0]          m_data;
    logic [SRCW-1:0]           m_src;
    logic                      m_last;
    logic                      m_valid;
    logic                      m_ready;
    logic [NREQ-1:0]           grant;
    logic                      busy;

    fifo_rd_arbiter #(
        .NREQ(NREQ), .SRCW(SRCW), .DSIZE(DSIZE), .ASIZE(ASIZE), .BURST(BURST)
    ) dut (
        .rd_clk        (rd_clk),
        .rd_rst_n      (rd_rst_n),
        .fifo_empty    (fifo_empty),
        .fifo_rd_count (fifo_rd_count),
        .fifo_dout     (fifo_dout),
        .fifo_rd_en    (fifo_rd_en),
        .m_data        (m_data),
        .m_src         (m_src),
        .m_last        (m_last),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .grant         (grant),
        .busy          (busy)
    );

    always #5 rd_clk = ~rd_clk;

    logic [7:0]  q [NREQ][$];
    int          ovr [NREQ];
    logic [7:0]  dout_r [NREQ];
    int          rd_cnt [NREQ];
    logic [10:0] obs [$];
    int          obs_cyc [$];
    logic [10:0] exp_q [$];
    logic [10:0] prev_word;
    logic [NREQ-1:0] snap;
    bit          prev_stall;
    int          cyc, total_rd, total_pop, max_pend, stab_err, multi_err;
    int          n_assert, n_fail;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_assert++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [10:0] wd(input int s, input bit l, input int d);
        return {2'(s), l, 8'(d)};
    endfunction

    task automatic refresh();
        for (int i = 0; i < NREQ; i++) begin
            fifo_empty[i] = (q[i].size() == 0);
            fifo_rd_count[i*(ASIZE+1) +: ASIZE+1] = (ovr[i] >= 0) ? 5'(ovr[i]) : 5'(q[i].size());
            fifo_dout[i*DSIZE +: DSIZE] = dout_r[i];
        end
    endtask

    function automatic bit any_q();
        bit r = 1'b0;
        for (int i = 0; i < NREQ; i++) if (q[i].size() != 0) r = 1'b1;
        return r;
    endfunction

    // One clock: observe at the falling edge, then update the FIFO models.
    task automatic tick();
        int pend;
        @(negedge rd_clk);
        cyc++;
        snap = fifo_rd_en;
        if ($countones(snap) > 1) multi_err++;
        for (int i = 0; i < NREQ; i++) rd_cnt[i] += int'(snap[i]);
        total_rd += $countones(snap);
        if (prev_stall && (!m_valid || ({m_src, m_last, m_data} !== prev_word))) stab_err++;
        prev_stall = m_valid && !m_ready;
        prev_word  = {m_src, m_last, m_data};
        if (m_valid && m_ready) begin
            obs.push_back({m_src, m_last, m_data});
            obs_cyc.push_back(cyc);
            total_pop++;
        end
        pend = total_rd - total_pop;
        if (pend > max_pend) max_pend = pend;
        @(posedge rd_clk);
        #1;
        for (int i = 0; i < NREQ; i++)
            if (snap[i] && q[i].size() > 0) dout_r[i] = q[i].pop_front();
        refresh();
    endtask

    task automatic start_scenario();
        obs.delete();
        obs_cyc.delete();
        exp_q.delete();
        for (int i = 0; i < NREQ; i++) rd_cnt[i] = 0;
        max_pend = 0;
        stab_err = 0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((busy || any_q()) && n < 300) begin
            tick();
            n++;
        end
        chk({tag, "_done"}, 32'(n < 300), 1);
    endtask

    task automatic chk_words(input string tag);
        chk({tag, "_count"}, obs.size(), exp_q.size());
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++)
            chk($sformatf("%s_w%0d", tag, i), obs[i], exp_q[i]);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rd_en"}, fifo_rd_en, 0);
        chk({tag, "_grant"}, grant, 0);
        chk({tag, "_valid"}, m_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_word"}, {m_src, m_last, m_data}, 0);
    endtask

    initial begin
        int n;
        n_assert = 0; n_fail = 0; cyc = 0; total_rd = 0; total_pop = 0;
        multi_err = 0; prev_stall = 1'b0; prev_word = '0; snap = '0;
        m_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            ovr[i] = -1;
            dout_r[i] = 8'h00;
        end
        refresh();
        start_scenario();

        // Reset state
        #2 rd_rst_n = 1'b0;
        #10;
        chk_reset_outputs("reset");
        tick();
        tick();
        rd_rst_n = 1'b1;

        // Single source, two bursts from FIFO0
        start_scenario();
        for (int i = 0; i < 6; i++) q[0].push_back(8'(8'h10 + i));
        refresh();
        drain("single");
        for (int i = 0; i < 4; i++) exp_q.push_back(wd(0, i == 3, 8'h10 + i));
        exp_q.push_back(wd(0, 0, 8'h14));
        exp_q.push_back(wd(0, 1, 8'h15));
        chk_words("single");
        chk("single_rd_cnt", rd_cnt[0], 6);
        if (obs_cyc.size() == 6) begin
            chk("single_b2b_1", obs_cyc[1] - obs_cyc[0], 1);
            chk("single_b2b_2", obs_cyc[2] - obs_cyc[1], 1);
            chk("single_b2b_3", obs_cyc[3] - obs_cyc[2], 1);
            chk("single_b2b_5", obs_cyc[5] - obs_cyc[4], 1);
        end

        // Reset in the middle of a FIFO1 burst
        start_scenario();
        for (int i = 0; i < 4; i++) q[1].push_back(8'(8'h20 + i));
        refresh();
        n = 0;
        while (grant !== 4'b0010 && n < 20) begin
            tick();
            n++;
        end
        chk("midrst_grant1", grant, 4'b0010);
        tick();
        tick();
        chk("midrst_busy_before", busy, 1);
        rd_rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        for (int i = 0; i < NREQ; i++) q[i].delete();
        refresh();
        tick();
        tick();
        rd_rst_n = 1'b1;
        total_rd = 0; total_pop = 0; prev_stall = 1'b0;

        // Round robin between FIFO0 and FIFO2; requester 0 goes first after reset
        start_scenario();
        for (int i = 0; i < 8; i++) begin
            q[0].push_back(8'(8'h30 + i));
            q[2].push_back(8'(8'h40 + i));
        end
        refresh();
        drain("rr");
        for (int b = 0; b < 2; b++) begin
            for (int j = 0; j < 4; j++) exp_q.push_back(wd(0, j == 3, 8'h30 + b*4 + j));
            for (int j = 0; j < 4; j++) exp_q.push_back(wd(2, j == 3, 8'h40 + b*4 + j));
        end
        chk_words("rr");

        // Backpressure: m_ready low five cycles after the first word
        start_scenario();
        for (int i = 0; i < 4; i++) q[0].push_back(8'(8'h50 + i));
        refresh();
        n = 0;
        while (obs.size() < 1 && n < 20) begin
            tick();
            n++;
        end
        m_ready = 1'b0;
        repeat (3) tick();
        chk("bp_valid_stalled", m_valid, 1);
        chk("bp_data_stalled", m_data, 8'h51);
        repeat (2) tick();
        m_ready = 1'b1;
        drain("bp");
        for (int i = 0; i < 4; i++) exp_q.push_back(wd(0, i == 3, 8'h50 + i));
        chk_words("bp");
        chk("bp_rd_cnt", rd_cnt[0], 4);
        chk("bp_max_outstanding", max_pend, 2);
        chk("bp_stable", stab_err, 0);

        // Stale zero count on a non-empty FIFO1
        start_scenario();
        q[1].push_back(8'h60);
        ovr[1] = 0;
        refresh();
        drain("stale");
        ovr[1] = -1;
        refresh();
        exp_q.push_back(wd(1, 1, 8'h60));
        chk_words("stale");
        chk("stale_rd_cnt", rd_cnt[1], 1);

        // Early empty: FIFO3 holds 2 words while reporting a count of 4
        start_scenario();
        q[3].push_back(8'h70);
        q[3].push_back(8'h71);
        ovr[3] = 4;
        refresh();
        drain("early");
        ovr[3] = -1;
        refresh();
        exp_q.push_back(wd(3, 0, 8'h70));
        exp_q.push_back(wd(3, 1, 8'h71));
        chk_words("early");
        chk("early_rd_cnt", rd_cnt[3], 2);
        chk("early_grant_idle", grant, 0);
        chk("early_busy_idle", busy, 0);

        chk("rd_en_onehot", multi_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
